key_match: RTL and testbench
============================

Name: key_match

Overview:
- Ternary match stage directly downstream of the key extractor in each RMT stage.
- Takes the PHV and extracted key from the extractor and compares the key against a small ternary table of key/mask entries.
- Forwards the PHV with a hit flag and the matching entry index to the action engine.
- Fixed 2-cycle pipeline at full throughput (one lookup per cycle).

Parameters:
- STAGE, 0, stage identifier (informational, carried for config decode symmetry).
- PHV_LEN, 48*8+32*8+16*8+5*20+256 (1124), PHV width.
- KEY_LEN, 48*2+32*2+16*2+5 (197), key width.
- DEPTH, 16, number of ternary entries (power of 2).
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- phv_in  in  PHV_LEN  PHV from key extractor
- phv_valid_in  in  1  PHV valid
- key_in  in  KEY_LEN  extracted key
- key_valid_in  in  1  key valid
- entry_wr_en  in  1  table write strobe
- entry_wr_addr  in  ADDR_W  entry index
- entry_key_in  in  KEY_LEN  entry key
- entry_mask_in  in  KEY_LEN  entry mask (1 = care bit)
- entry_valid_in  in  1  entry valid bit (0 deletes the entry)
- phv_out  out  PHV_LEN  delayed PHV
- phv_valid_out  out  1  PHV valid
- hit_out  out  1  at least one valid entry matched
- match_addr_out  out  ADDR_W  lowest matching index; 0 on miss

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All entry valid bits cleared; entry key/mask contents don't-care.
  - phv_out=0, phv_valid_out=0, hit_out=0, match_addr_out=0.
  - Both pipeline valids cleared; in-flight lookups are dropped, never emitted.
- Match rule: entry i matches when valid[i] and ((key ^ key[i]) & mask[i]) == 0. An all-zero mask on a valid entry matches every key.
- Cycle 1 (S1):
  - Register phv_in, phv_valid_in, and the DEPTH-bit match vector.
  - If phv_valid_in=1 and key_valid_in=0, the match vector is forced to 0, so the PHV is forwarded as a miss.
  - key_valid_in without phv_valid_in is ignored.
- Cycle 2 (S2):
  - Priority-encode the match vector; lowest index wins.
  - Register phv_out, phv_valid_out, hit_out=|vector, match_addr_out.
- Latency: input at edge N appears on outputs after edge N+2; back-to-back inputs give back-to-back outputs, no stalls.
- When phv_valid_out=0: hit_out=0 and match_addr_out=0; phv_out holds its last value.
- Table writes:
  - Take effect at the clock edge where entry_wr_en=1.
  - A lookup in the same cycle as a write to the same index uses the pre-write contents.
  - The next cycle's lookup uses the new contents.
- Only one write per cycle. A write with entry_valid_in=0 invalidates the entry.
- No backpressure: the downstream stage must always accept.

Optional Feature:
- Macro: KEY_MATCH_STATS_EN.
- When defined:
  - Adds outputs hit_cnt_out[31:0] and miss_cnt_out[31:0].
  - Incremented in S2 when phv_valid_out is set with hit/miss respectively.
  - Counters wrap at 2^32-1 to 0; reset to 0.
  - Adds input stats_clr (1 bit), which zeroes both counters; clear wins over a same-cycle increment.
- When not defined: these ports and registers do not exist; match behaviour is identical.

Decomposition:
- Shared package rmt_pkg:
  - PHV_LEN and KEY_LEN constants, shared with the extractor.
  - Default DEPTH.
  - A struct type for a ternary entry {valid, key, mask}.
- One sub-module: key_match_prio_enc, a parameterised DEPTH to ADDR_W lowest-index priority encoder with an any-hit output.
- The table storage and comparators stay in key_match.

Test Plan:
- Reset, then lookup key=197'h1234 with an empty table -> after 2 cycles phv_valid_out=1, hit_out=0, match_addr_out=0, phv_out equal to the input PHV.
- Write entry 3 {key=197'hABCD, mask=all ones, valid=1}; lookup 197'hABCD -> hit_out=1, match_addr_out=3. Lookup 197'hABCE -> hit_out=0.
- Entry 5 with mask=all zeros and entry 2 exact 197'h55, both valid; lookup 197'h55 -> match_addr_out=2. Lookup 197'h66 -> match_addr_out=5.
- Write entry 3 valid=0 in the same cycle as a lookup of 197'hABCD -> that lookup hits index 3; the next-cycle lookup misses.
- Four back-to-back PHVs with distinct keys -> four consecutive valid outputs in order, 2-cycle latency. Assert rst_n low while two lookups are in flight -> no outputs emitted and all outputs 0.
- With KEY_MATCH_STATS_EN, 3 hits and 2 misses -> hit_cnt_out=3, miss_cnt_out=2. stats_clr coinciding with a hit -> both counters 0.

Source files
------------

// File: rtl/rmt_pkg.sv
// rmt_pkg: widths and types shared by the RMT stage blocks (extractor, key match, action).
// entry_t is one ternary table slot; a mask bit of 1 marks a care bit.
package rmt_pkg;

    localparam int PHV_LEN   = 48*8 + 32*8 + 16*8 + 5*20 + 256;
    localparam int KEY_LEN   = 48*2 + 32*2 + 16*2 + 5;
    localparam int DEF_DEPTH = 16;

    typedef struct packed {
        logic               valid;
        logic [KEY_LEN-1:0] key;
        logic [KEY_LEN-1:0] mask;
    } entry_t;

    function automatic logic ternary_hit(entry_t e, logic [KEY_LEN-1:0] key);
        return e.valid && (((key ^ e.key) & e.mask) == '0);
    endfunction

endpackage

// File: rtl/key_match_if.sv
// key_match_if: lookup inputs, table-write port and match results of key_match.
// Counter ports exist only when KEY_MATCH_STATS_EN is defined.
interface key_match_if import rmt_pkg::*; #(
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) ();

    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic [KEY_LEN-1:0] key_in;
    logic               key_valid_in;
    logic               entry_wr_en;
    logic [ADDR_W-1:0]  entry_wr_addr;
    logic [KEY_LEN-1:0] entry_key_in;
    logic [KEY_LEN-1:0] entry_mask_in;
    logic               entry_valid_in;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic               hit_out;
    logic [ADDR_W-1:0]  match_addr_out;
`ifdef KEY_MATCH_STATS_EN
    logic               stats_clr;
    logic [31:0]        hit_cnt_out;
    logic [31:0]        miss_cnt_out;
`endif

    modport master (
        output phv_in, phv_valid_in, key_in, key_valid_in,
        output entry_wr_en, entry_wr_addr, entry_key_in, entry_mask_in, entry_valid_in,
`ifdef KEY_MATCH_STATS_EN
        output stats_clr,
        input  hit_cnt_out, miss_cnt_out,
`endif
        input  phv_out, phv_valid_out, hit_out, match_addr_out
    );

    modport slave (
        input  phv_in, phv_valid_in, key_in, key_valid_in,
        input  entry_wr_en, entry_wr_addr, entry_key_in, entry_mask_in, entry_valid_in,
`ifdef KEY_MATCH_STATS_EN
        input  stats_clr,
        output hit_cnt_out, miss_cnt_out,
`endif
        output phv_out, phv_valid_out, hit_out, match_addr_out
    );

endinterface

// File: rtl/key_match_prio_enc.sv
// key_match_prio_enc: lowest-index priority encoder with an any-hit flag.
module key_match_prio_enc #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  vec,
    output logic              any,
    output logic [ADDR_W-1:0] idx
);

    // Scan high to low so the lowest set bit is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (vec[i]) idx = ADDR_W'(i);
    end

    assign any = |vec;

endmodule

// File: rtl/key_match.sv
// key_match: 2-stage ternary lookup of the extracted key, forwarding the PHV with hit/index.
// Optional hit/miss counters are built when KEY_MATCH_STATS_EN is defined.
module key_match import rmt_pkg::*; #(
    parameter int STAGE  = 0,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        rst_n,
    key_match_if.slave bus
);

    entry_t             tbl [DEPTH];
    logic [DEPTH-1:0]   match;
    logic [DEPTH-1:0]   match_s1;
    logic [PHV_LEN-1:0] phv_s1;
    logic               valid_s1;
    logic               any_s1;
    logic [ADDR_W-1:0]  idx_s1;

    // Writes land at the edge, so a same-cycle lookup still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (bus.entry_wr_en) begin
            tbl[bus.entry_wr_addr] <= '{valid: bus.entry_valid_in,
                                        key:   bus.entry_key_in,
                                        mask:  bus.entry_mask_in};
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) match[i] = ternary_hit(tbl[i], bus.key_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            match_s1 <= '0;
            phv_s1   <= '0;
        end else begin
            valid_s1 <= bus.phv_valid_in;
            match_s1 <= (bus.phv_valid_in && bus.key_valid_in) ? match : '0;
            if (bus.phv_valid_in) phv_s1 <= bus.phv_in;
        end
    end

    key_match_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prio_enc (
        .vec (match_s1),
        .any (any_s1),
        .idx (idx_s1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.phv_out        <= '0;
            bus.phv_valid_out  <= 1'b0;
            bus.hit_out        <= 1'b0;
            bus.match_addr_out <= '0;
        end else begin
            bus.phv_valid_out  <= valid_s1;
            bus.hit_out        <= valid_s1 && any_s1;
            bus.match_addr_out <= valid_s1 ? idx_s1 : '0;
            if (valid_s1) bus.phv_out <= phv_s1;
        end
    end

`ifdef KEY_MATCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hit_cnt_out  <= '0;
            bus.miss_cnt_out <= '0;
        end else if (bus.stats_clr) begin
            bus.hit_cnt_out  <= '0;
            bus.miss_cnt_out <= '0;
        end else if (valid_s1) begin
            if (any_s1) bus.hit_cnt_out <= bus.hit_cnt_out + 32'd1;
            else        bus.miss_cnt_out <= bus.miss_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_match.sv
// tb_key_match: table vectors, hand sequences and random traffic against a reference table model.
module tb_key_match;
    import rmt_pkg::*;

    localparam int AW = 4;
    localparam int N  = 16;
    localparam logic [KEY_LEN-1:0] ONES = {KEY_LEN{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_match_if #(.ADDR_W(AW)) bus ();
    key_match #(.STAGE(0), .DEPTH(N), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic               valid;
        logic               hit;
        logic [AW-1:0]      addr;
        logic [PHV_LEN-1:0] phv;
        string              name;
    } exp_t;

    typedef struct {
        logic               we;
        logic [AW-1:0]      wa;
        logic [KEY_LEN-1:0] wk;
        logic [KEY_LEN-1:0] wm;
        logic               wv;
        logic               pv;
        logic               kv;
        logic [KEY_LEN-1:0] key;
        logic               hit;
        logic [AW-1:0]      addr;
    } vec_t;

    exp_t               exp_q[$];
    logic               m_valid [N];
    logic [KEY_LEN-1:0] m_key   [N];
    logic [KEY_LEN-1:0] m_mask  [N];

    function automatic exp_t mk(logic v, logic h, logic [AW-1:0] a, logic [PHV_LEN-1:0] p, string n);
        exp_t e;
        e.valid = v;
        e.hit   = v && h;
        e.addr  = v ? a : '0;
        e.phv   = p;
        e.name  = n;
        return e;
    endfunction

    // Reference: scan the whole table and keep the lowest matching index.
    function automatic exp_t predict(logic pv, logic kv, logic [KEY_LEN-1:0] key, logic [PHV_LEN-1:0] phv, string n);
        exp_t e = mk(pv, 1'b0, '0, phv, n);
        if (pv && kv)
            for (int i = N - 1; i >= 0; i--)
                if (m_valid[i] && ((key ^ m_key[i]) & m_mask[i]) == '0) begin
                    e.hit  = 1'b1;
                    e.addr = AW'(i);
                end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_mask[i]  = '0;
        end
    endfunction

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [PHV_LEN-1:0] p = '0;
        for (int i = 0; i < (PHV_LEN + 31) / 32; i++) p = {p[PHV_LEN-33:0], 32'($urandom)};
        return p;
    endfunction

    task automatic check_out(exp_t e);
        logic ok;
        checks++;
        ok = bus.phv_valid_out === e.valid && bus.hit_out === e.hit &&
             bus.match_addr_out === e.addr && (!e.valid || bus.phv_out === e.phv);
        if (ok) passed++;
        else $display("FAIL %s: got valid=%b hit=%b addr=%0d phv_ok=%b, want valid=%b hit=%b addr=%0d",
                      e.name, bus.phv_valid_out, bus.hit_out, bus.match_addr_out,
                      bus.phv_out === e.phv, e.valid, e.hit, e.addr);
    endtask

    task automatic check_zero(string name);
        checks++;
        if (bus.phv_valid_out === 1'b0 && bus.hit_out === 1'b0 && bus.match_addr_out === '0 && bus.phv_out === '0)
            passed++;
        else $display("FAIL %s: got valid=%b hit=%b addr=%0d phv_zero=%b, want all zero",
                      name, bus.phv_valid_out, bus.hit_out, bus.match_addr_out, bus.phv_out === '0);
    endtask

`ifdef KEY_MATCH_STATS_EN
    task automatic check_cnt(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, want);
    endtask
`endif

    // One cycle: drive inputs, queue the expectation, mirror the write into the model,
    // then compare the output belonging to the lookup from two cycles back.
    task automatic step(input logic pv, input logic kv, input logic [KEY_LEN-1:0] key,
                        input logic [PHV_LEN-1:0] phv, input logic we, input logic [AW-1:0] wa,
                        input logic [KEY_LEN-1:0] wk, input logic [KEY_LEN-1:0] wm, input logic wv,
                        input exp_t e);
        bus.phv_valid_in   = pv;
        bus.key_valid_in   = kv;
        bus.key_in         = key;
        bus.phv_in         = phv;
        bus.entry_wr_en    = we;
        bus.entry_wr_addr  = wa;
        bus.entry_key_in   = wk;
        bus.entry_mask_in  = wm;
        bus.entry_valid_in = wv;
        exp_q.push_back(e);
        if (we) begin
            m_valid[wa] = wv;
            m_key[wa]   = wk;
            m_mask[wa]  = wm;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) check_out(exp_q.pop_front());
    endtask

    task automatic lookup(logic [KEY_LEN-1:0] key, string name);
        logic [PHV_LEN-1:0] p = rand_phv();
        step(1'b1, 1'b1, key, p, 1'b0, '0, '0, '0, 1'b0, predict(1'b1, 1'b1, key, p, name));
    endtask

    task automatic write(logic [AW-1:0] wa, logic [KEY_LEN-1:0] wk, logic [KEY_LEN-1:0] wm, logic wv, string name);
        step(1'b0, 1'b0, '0, '0, 1'b1, wa, wk, wm, wv, mk(1'b0, 1'b0, '0, '0, name));
    endtask

    task automatic idle(int n, string name);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, mk(1'b0, 1'b0, '0, '0, name));
    endtask

    task automatic do_reset(string name);
        rst_n = 1'b0;
        bus.phv_valid_in = 1'b0;
        bus.key_valid_in = 1'b0;
        bus.entry_wr_en  = 1'b0;
`ifdef KEY_MATCH_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        #1;
        check_zero(name);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        model_clear();
    endtask

    vec_t vt[14];

    initial begin
        vt = '{
            '{0, 0, 0,          0,    0, 1, 1, 197'h1234, 0, 0},
            '{1, 3, 197'hABCD,  ONES, 1, 0, 0, 0,         0, 0},
            '{0, 0, 0,          0,    0, 1, 1, 197'hABCD, 1, 3},
            '{0, 0, 0,          0,    0, 1, 1, 197'hABCE, 0, 0},
            '{1, 5, 0,          0,    1, 1, 1, 197'h55,   0, 0},
            '{1, 2, 197'h55,    ONES, 1, 1, 1, 197'h66,   1, 5},
            '{0, 0, 0,          0,    0, 1, 1, 197'h55,   1, 2},
            '{0, 0, 0,          0,    0, 1, 1, 197'h66,   1, 5},
            '{1, 5, 0,          0,    0, 1, 1, 197'h66,   1, 5},
            '{0, 0, 0,          0,    0, 1, 1, 197'h66,   0, 0},
            '{0, 0, 0,          0,    0, 1, 0, 197'h55,   0, 0},
            '{0, 0, 0,          0,    0, 0, 1, 197'h55,   0, 0},
            '{1, 3, 197'hABCD,  ONES, 0, 1, 1, 197'hABCD, 1, 3},
            '{0, 0, 0,          0,    0, 1, 1, 197'hABCD, 0, 0}
        };
        bus.phv_in = '0;
        bus.key_in = '0;
        bus.entry_wr_addr  = '0;
        bus.entry_key_in   = '0;
        bus.entry_mask_in  = '0;
        bus.entry_valid_in = 1'b0;
        do_reset("reset_state");

        for (int i = 0; i < 14; i++) begin
            logic [PHV_LEN-1:0] p = rand_phv();
            step(vt[i].pv, vt[i].kv, vt[i].key, p, vt[i].we, vt[i].wa, vt[i].wk, vt[i].wm, vt[i].wv,
                 mk(vt[i].pv, vt[i].hit, vt[i].addr, p, $sformatf("vec%0d", i)));
        end
        idle(2, "vec_drain");

        lookup(197'h55, "b2b_0");
        lookup(197'h1234, "b2b_1");
        lookup(197'hABCD, "b2b_2");
        lookup(197'h66, "b2b_3");
        idle(2, "b2b_drain");

        write(4'd7, 197'h77, ONES, 1'b1, "pre_rst_wr");
        lookup(197'h77, "inflight_0");
        bus.key_in = 197'h77;
        bus.phv_in = rand_phv();
        do_reset("rst_inflight");
        check_zero("rst_held");
        idle(3, "post_rst_idle");
        lookup(197'h77, "post_rst_cleared");
        idle(2, "post_rst_drain");

        for (int i = 0; i < 400; i++) begin
            logic               pv = ($urandom_range(0, 3) != 0);
            logic               kv = ($urandom_range(0, 7) != 0);
            logic [KEY_LEN-1:0] key = KEY_LEN'($urandom_range(0, 15));
            logic               we = ($urandom_range(0, 3) == 0);
            logic [KEY_LEN-1:0] wm = ($urandom_range(0, 7) == 0) ? '0 : ONES ^ KEY_LEN'($urandom_range(0, 15));
            logic [PHV_LEN-1:0] p = rand_phv();
            if ($urandom_range(0, 7) == 0) key[150] = 1'b1;
            step(pv, kv, key, p, we, AW'($urandom_range(0, N - 1)), KEY_LEN'($urandom_range(0, 15)), wm,
                 ($urandom_range(0, 4) != 0), predict(pv, kv, key, p, $sformatf("rand%0d", i)));
        end
        idle(2, "rand_drain");

`ifdef KEY_MATCH_STATS_EN
        do_reset("stats_reset");
        check_cnt("hit_cnt_reset", bus.hit_cnt_out, 32'd0);
        check_cnt("miss_cnt_reset", bus.miss_cnt_out, 32'd0);
        write(4'd1, 197'h7, ONES, 1'b1, "stats_wr");
        lookup(197'h7, "stats_h0");
        lookup(197'h8, "stats_m0");
        lookup(197'h7, "stats_h1");
        lookup(197'h8, "stats_m1");
        lookup(197'h7, "stats_h2");
        idle(2, "stats_drain");
        check_cnt("hit_cnt", bus.hit_cnt_out, 32'd3);
        check_cnt("miss_cnt", bus.miss_cnt_out, 32'd2);
        lookup(197'h7, "stats_clr_hit");
        bus.stats_clr = 1'b1;
        idle(1, "stats_clr_edge");
        bus.stats_clr = 1'b0;
        idle(1, "stats_clr_drain");
        check_cnt("hit_cnt_clr", bus.hit_cnt_out, 32'd0);
        check_cnt("miss_cnt_clr", bus.miss_cnt_out, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
